phantom_rtc: RTL and testbench



---
 rtl/phantom_rtc_pkg.sv | 15 +
 rtl/phantom_rtc_bcd_field_ctr.sv | 24 ++
 rtl/phantom_rtc.sv | 103 ++++++++++
 tb/tb_phantom_rtc.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/phantom_rtc_pkg.sv
// phantom_rtc_pkg: shared constants, byte layout and types for the phantom RTC
package phantom_rtc_pkg;
    localparam logic [63:0] PATTERN = 64'h5CA33AC55CA33AC5;
    localparam int DIV = 71591;
    localparam int HSEC = 0;
    localparam int SEC = 1;
    localparam int MIN = 2;
    localparam int HR = 3;
    localparam int DAY = 4;
    localparam int DATE = 5;
    localparam int MON = 6;
    localparam int YR = 7;
    typedef logic [7:0] bcd_t;
    typedef enum logic {IDLE, ACTIVE} state_t;
endpackage

// File: rtl/phantom_rtc_bcd_field_ctr.sv
// bcd_field_ctr: two-digit BCD field counter with load, wrap to MIN_WRAP and carry out
module bcd_field_ctr
    import phantom_rtc_pkg::*;
#(
    parameter bcd_t MAX = 8'h99,
    parameter bcd_t MIN_WRAP = 8'h00
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic load,
    input  bcd_t din,
    output bcd_t q,
    output logic carry
);
    bcd_t nxt;
    assign carry = inc & (q == MAX);
    // invalid BCD digits fall through to the nibble rule and settle on their own
    always_comb nxt = (q == MAX) ? MIN_WRAP : (q[3:0] >= 4'd9) ? {q[7:4] + 4'd1, 4'h0} : q + 8'd1;
    always_ff @(posedge clk or negedge reset)
        if (!reset) q <= MIN_WRAP;
        else if (load) q <= din;
        else if (inc) q <= nxt;
endmodule

// File: rtl/phantom_rtc.sv
// phantom_rtc: pattern-unlocked serial RTC hiding behind the card ROM/SRAM chip select
module phantom_rtc
    import phantom_rtc_pkg::*;
#(
    parameter int DIV_CNT = DIV
) (
    input  logic C7M,
    input  logic nRES,
    input  logic nCSin,
    input  logic Latch,
    input  logic nWE,
    input  logic A2,
    input  logic D0in,
    output logic CSgb,
    output logic D0out,
    output logic D0OE
);
    localparam int PW = $clog2(DIV_CNT);
    localparam logic [PW-1:0] PRE_MAX = PW'(DIV_CNT - 1);
    state_t state, state_nxt;
    logic [5:0] ptr, ptr_nxt, bit_cnt, bit_nxt;
    logic wrote, wrote_nxt, commit, qual, b, tick;
    logic [63:0] shift, shift_nxt, live;
    logic [PW-1:0] pre;
    bcd_t hsec, sec, minute, hr, day, date, mon, yr;
    logic c_hsec, c_sec, c_min, c_hr, unused_day_carry;
    assign qual = Latch & ~nCSin;
    assign b = nWE ? A2 : D0in;
    assign tick = pre == PRE_MAX;
    assign live = {yr, mon, date, day, hr, minute, sec, hsec};
    assign CSgb = ~nCSin & (state == IDLE);
    assign D0OE = (state == ACTIVE) & ~nCSin & nWE;
    assign D0out = (state == ACTIVE) & shift[bit_cnt];
    always_comb begin
        state_nxt = state;
        ptr_nxt = ptr;
        bit_nxt = bit_cnt;
        wrote_nxt = wrote;
        shift_nxt = shift;
        commit = 1'b0;
        if (qual && state == IDLE) begin
            ptr_nxt = (b == PATTERN[ptr]) ? ptr + 6'd1 : 6'd0;
            if (b == PATTERN[ptr] && ptr == 6'd63) begin
                state_nxt = ACTIVE;
                bit_nxt = 6'd0;
                wrote_nxt = 1'b0;
                shift_nxt = live;
            end
        end else if (qual) begin
            if (!nWE) begin
                shift_nxt[bit_cnt] = D0in;
                wrote_nxt = 1'b1;
            end
            bit_nxt = bit_cnt + 6'd1;
            // the final transfer's own write bit is part of the committed image
            if (bit_cnt == 6'd63) begin
                state_nxt = IDLE;
                ptr_nxt = 6'd0;
                commit = wrote_nxt;
            end
        end
    end
    always_ff @(posedge C7M or negedge nRES)
        if (!nRES) begin
            state <= IDLE;
            ptr <= 6'd0;
            bit_cnt <= 6'd0;
            wrote <= 1'b0;
            shift <= 64'd0;
            pre <= '0;
        end else begin
            state <= state_nxt;
            ptr <= ptr_nxt;
            bit_cnt <= bit_nxt;
            wrote <= wrote_nxt;
            shift <= shift_nxt;
            pre <= (commit | tick) ? '0 : pre + PW'(1);
        end
    always_ff @(posedge C7M or negedge nRES)
        if (!nRES) {yr, mon, date} <= {8'h00, 8'h01, 8'h01};
        else if (commit) {yr, mon, date} <= {shift_nxt[YR*8 +: 8], shift_nxt[MON*8 +: 8], shift_nxt[DATE*8 +: 8]};
    // a commit loads every field, so it overrides a same-edge tick
    bcd_field_ctr #(.MAX(8'h99), .MIN_WRAP(8'h00)) u_hsec (
        .clk(C7M), .reset(nRES), .inc(tick), .load(commit),
        .din(shift_nxt[HSEC*8 +: 8]), .q(hsec), .carry(c_hsec)
    );
    bcd_field_ctr #(.MAX(8'h59), .MIN_WRAP(8'h00)) u_sec (
        .clk(C7M), .reset(nRES), .inc(c_hsec), .load(commit),
        .din(shift_nxt[SEC*8 +: 8]), .q(sec), .carry(c_sec)
    );
    bcd_field_ctr #(.MAX(8'h59), .MIN_WRAP(8'h00)) u_min (
        .clk(C7M), .reset(nRES), .inc(c_sec), .load(commit),
        .din(shift_nxt[MIN*8 +: 8]), .q(minute), .carry(c_min)
    );
    bcd_field_ctr #(.MAX(8'h23), .MIN_WRAP(8'h00)) u_hr (
        .clk(C7M), .reset(nRES), .inc(c_min), .load(commit),
        .din(shift_nxt[HR*8 +: 8]), .q(hr), .carry(c_hr)
    );
    bcd_field_ctr #(.MAX(8'h07), .MIN_WRAP(8'h01)) u_day (
        .clk(C7M), .reset(nRES), .inc(c_hr), .load(commit),
        .din({5'd0, shift_nxt[DAY*8 +: 3]}), .q(day), .carry(unused_day_carry)
    );
endmodule

// File: tb/tb_phantom_rtc.sv
// tb_phantom_rtc: randomized self-checking bench against a decimal time-of-day model
module tb_phantom_rtc;
    import phantom_rtc_pkg::*;
    localparam int TDIV = 400;
    logic C7M = 1'b0, nRES = 1'b0, nCSin = 1'b1, Latch = 1'b0, nWE = 1'b1, A2 = 1'b0, D0in = 1'b0;
    logic CSgb, D0out, D0OE;
    phantom_rtc #(.DIV_CNT(TDIV)) dut (
        .C7M(C7M), .nRES(nRES), .nCSin(nCSin), .Latch(Latch), .nWE(nWE),
        .A2(A2), .D0in(D0in), .CSgb(CSgb), .D0out(D0out), .D0OE(D0OE)
    );
    always #5 C7M = ~C7M;
    int cyc = 0;
    always @(posedge C7M) cyc <= cyc + 1;
    int n_cmp = 0, n_bad = 0;
    int base_e = 0, last_e = 0, entry_e = 0;
    int bt[8];
    logic [63:0] pat = PATTERN;
    logic s_cs, s_oe, s_d0;

    function automatic logic [63:0] image_of(input int f[8]);
        logic [63:0] r;
        for (int k = 0; k < 8; k++) r[k*8 +: 8] = 8'((f[k] / 10) * 16 + f[k] % 10);
        return r;
    endfunction

    // time visible just before absolute edge e: whole ticks elapsed since the last reset/commit
    function automatic logic [63:0] model_at(input int e);
        int f[8];
        int n;
        f = bt;
        n = (e - 1 - base_e) / TDIV;
        for (int t = 0; t < n; t++) begin
            f[0]++;
            if (f[0] == 100) begin
                f[0] = 0; f[1]++;
                if (f[1] == 60) begin
                    f[1] = 0; f[2]++;
                    if (f[2] == 60) begin
                        f[2] = 0; f[3]++;
                        if (f[3] == 24) begin
                            f[3] = 0;
                            f[4] = (f[4] == 7) ? 1 : f[4] + 1;
                        end
                    end
                end
            end
        end
        return image_of(f);
    endfunction

    task automatic rand_time(output int f[8]);
        f[0] = int'($urandom_range(0, 99)); f[1] = int'($urandom_range(0, 59));
        f[2] = int'($urandom_range(0, 59)); f[3] = int'($urandom_range(0, 23));
        f[4] = int'($urandom_range(1, 7)); f[5] = int'($urandom_range(1, 31));
        f[6] = int'($urandom_range(1, 12)); f[7] = int'($urandom_range(0, 99));
    endtask

    task automatic access(input logic we, input logic bit_in);
        @(negedge C7M);
        nCSin = 1'b0; Latch = 1'b1; nWE = ~we;
        A2 = we ? 1'($urandom) : bit_in;
        D0in = we ? bit_in : 1'($urandom);
        #1 s_cs = CSgb; s_oe = D0OE; s_d0 = D0out;
        @(posedge C7M);
        #1 last_e = cyc;
        @(negedge C7M);
        Latch = 1'b0; nCSin = 1'b1;
    endtask

    task automatic wait_edge(input int target);
        while (cyc + 2 < target) @(negedge C7M);
    endtask

    task automatic send_pattern(input logic we, input int align);
        for (int i = 0; i < 64; i++) begin
            if (i == 63 && align > 0) wait_edge(align);
            access(we, pat[i]);
            n_cmp++;
            if (s_cs !== 1'b1) begin n_bad++; $display("FAIL pattern_ungated bit %0d: CSgb=%b expected 1", i, s_cs); end
        end
        entry_e = last_e;
        if (align > 0) begin
            n_cmp++;
            if (last_e != align) begin n_bad++; $display("FAIL entry_align: edge %0d expected %0d", last_e, align); end
        end
    endtask

    task automatic read_image(output logic [63:0] img, input int stray_at);
        logic [63:0] r;
        for (int i = 0; i < 64; i++) begin
            if (i == stray_at) begin
                for (int k = 0; k < 3; k++) begin
                    @(negedge C7M); Latch = 1'b1; nCSin = 1'b1; nWE = 1'b1;
                    #1 n_cmp++;
                    if (D0OE !== 1'b0 || CSgb !== 1'b0) begin
                        n_bad++; $display("FAIL stray_latch: D0OE=%b CSgb=%b expected 0 0", D0OE, CSgb);
                    end
                    @(negedge C7M); Latch = 1'b0;
                end
            end
            access(1'b0, 1'($urandom));
            r[i] = s_d0;
            n_cmp++;
            if (s_cs !== 1'b0 || s_oe !== 1'b1) begin
                n_bad++; $display("FAIL transfer_gate bit %0d: CSgb=%b D0OE=%b expected 0 1", i, s_cs, s_oe);
            end
        end
        img = r;
        access(1'b0, 1'b0);
        n_cmp++;
        if (s_cs !== 1'b1 || s_oe !== 1'b0) begin
            n_bad++; $display("FAIL after_transfer: CSgb=%b D0OE=%b expected 1 0", s_cs, s_oe);
        end
    endtask

    task automatic write_image(input int f[8], input int align);
        logic [63:0] img;
        img = image_of(f);
        for (int i = 0; i < 64; i++) begin
            if (i == 63 && align > 0) wait_edge(align);
            access(1'b1, img[i]);
            n_cmp++;
            if (s_cs !== 1'b0 || s_oe !== 1'b0) begin
                n_bad++; $display("FAIL write_gate bit %0d: CSgb=%b D0OE=%b expected 0 0", i, s_cs, s_oe);
            end
        end
        if (align > 0) begin
            n_cmp++;
            if (last_e != align) begin n_bad++; $display("FAIL commit_align: edge %0d expected %0d", last_e, align); end
        end
        bt = f;
        base_e = last_e;
    endtask

    task automatic read_and_check(input string name, input int align, input int stray_at);
        logic [63:0] got, exp;
        send_pattern(1'b0, align);
        exp = model_at(entry_e);
        read_image(got, stray_at);
        n_cmp++;
        if (got !== exp) begin n_bad++; $display("FAIL %s: image %h expected %h", name, got, exp); end
    endtask

    task automatic test_reset;
        repeat (3) @(negedge C7M);
        nCSin = 1'b0;
        #1 n_cmp++;
        if (CSgb !== 1'b1 || D0OE !== 1'b0 || D0out !== 1'b0) begin
            n_bad++; $display("FAIL reset_cs_low: CSgb=%b D0OE=%b D0out=%b expected 1 0 0", CSgb, D0OE, D0out);
        end
        nCSin = 1'b1;
        #1 n_cmp++;
        if (CSgb !== 1'b0 || D0OE !== 1'b0) begin
            n_bad++; $display("FAIL reset_cs_high: CSgb=%b D0OE=%b expected 0 0", CSgb, D0OE);
        end
        @(negedge C7M);
        nRES = 1'b1;
        base_e = cyc;
        bt = '{0, 0, 0, 0, 1, 1, 1, 0};
    endtask

    task automatic test_read_match;
        read_and_check("read_reset_image", 0, -1);
        n_cmp++;
        if (bt[4] != 1 || image_of(bt) !== 64'h0001_0101_0000_0000) begin
            n_bad++; $display("FAIL reset_model: image %h expected 0001010100000000", image_of(bt));
        end
    endtask

    task automatic test_bad_pattern;
        for (int i = 0; i <= 40; i++) begin
            access(1'b0, (i == 40) ? ~pat[i] : pat[i]);
            n_cmp++;
            if (s_cs !== 1'b1) begin n_bad++; $display("FAIL bad_pattern bit %0d: CSgb=%b expected 1", i, s_cs); end
        end
        for (int k = 0; k < 3; k++) begin
            access(1'b0, 1'b0);
            n_cmp++;
            if (s_cs !== 1'b1 || s_oe !== 1'b0) begin
                n_bad++; $display("FAIL bad_pattern_probe: CSgb=%b D0OE=%b expected 1 0", s_cs, s_oe);
            end
        end
        send_pattern(1'b1, 0);
        begin
            logic [63:0] got, exp;
            exp = model_at(entry_e);
            read_image(got, -1);
            n_cmp++;
            if (got !== exp) begin n_bad++; $display("FAIL rematch_via_writes: image %h expected %h", got, exp); end
        end
    endtask

    task automatic test_write_rollover;
        int f[8];
        logic [63:0] got;
        rand_time(f);
        f[0] = 99; f[1] = 59; f[2] = 59; f[3] = 23; f[4] = 7;
        send_pattern(1'b1, 0);
        write_image(f, 0);
        send_pattern(1'b0, base_e + TDIV + 1 + int'($urandom_range(0, 100)));
        read_image(got, -1);
        n_cmp++;
        if (got[39:0] !== 40'h01_00_00_00_00 || got[63:40] !== image_of(f) >> 40) begin
            n_bad++; $display("FAIL rollover: image %h expected %h", got, {image_of(f) >> 40, 40'h01_00_00_00_00} );
        end
    endtask

    task automatic test_random_write;
        int f[8];
        for (int n = 0; n < 3; n++) begin
            rand_time(f);
            send_pattern(1'b1, 0);
            write_image(f, 0);
            read_and_check("random_write_readback", 0, -1);
        end
    endtask

    task automatic test_commit_wrap;
        int f[8];
        int t;
        logic [63:0] got;
        rand_time(f);
        send_pattern(1'b1, 0);
        t = base_e + TDIV;
        while (t < cyc + 160) t += TDIV;
        write_image(f, t);
        send_pattern(1'b0, t + TDIV);
        read_image(got, -1);
        n_cmp++;
        if (got !== image_of(f)) begin n_bad++; $display("FAIL commit_wins_tick: image %h expected %h", got, image_of(f)); end
        read_and_check("commit_wrap_two_ticks", t + 2 * TDIV + 1, -1);
    endtask

    task automatic test_stray_latch;
        read_and_check("stray_latch_image", 0, 1 + int'($urandom_range(0, 61)));
    endtask

    task automatic test_reset_mid;
        send_pattern(1'b0, 0);
        for (int i = 0; i < 30; i++) access(1'b0, 1'($urandom));
        @(negedge C7M);
        nCSin = 1'b0;
        #2 nRES = 1'b0;
        #1 n_cmp++;
        if (CSgb !== 1'b1 || D0OE !== 1'b0 || D0out !== 1'b0) begin
            n_bad++; $display("FAIL mid_reset: CSgb=%b D0OE=%b D0out=%b expected 1 0 0", CSgb, D0OE, D0out);
        end
        nCSin = 1'b1;
        @(negedge C7M);
        nRES = 1'b1;
        base_e = cyc;
        bt = '{0, 0, 0, 0, 1, 1, 1, 0};
        read_and_check("after_mid_reset", 0, -1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        test_reset;
        test_read_match;
        test_bad_pattern;
        test_write_rollover;
        test_random_write;
        test_commit_wrap;
        test_stray_latch;
        test_reset_mid;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
